// File: rtl/bgm_sequencer_if.sv
// Control and song-ROM bundle for the background-music sequencer.
// The slave side is the sequencer; the master drives commands and the ROM data.
interface bgm_sequencer_if #(
   parameter int AW = 5
);
   logic          start;
   logic          stop;
   logic          loop_mode;
   logic [AW-1:0] song_addr;
   logic [3:0]    song_note;
   logic          speaker;
   logic          busy;
   logic          step_tick;
   logic          done;

   modport master (
      output start, stop, loop_mode, song_note,
      input  song_addr, speaker, busy, step_tick, done
   );

   modport slave (
      input  start, stop, loop_mode, song_note,
      output song_addr, speaker, busy, step_tick, done
   );
endinterface

// File: rtl/bgm_sequencer.sv
// Steps through a song ROM one note per step and renders each note
// as a staccato square wave on the speaker output.
module bgm_sequencer #(
   parameter int STEP_CYCLES = 10714284,
   parameter int GAP_CYCLES  = 1785714,
   parameter int NUM_STEPS   = 32,
   parameter int TONE_SHIFT  = 0
) (
   input logic            clk,
   input logic            reset,
   bgm_sequencer_if.slave bus
);
   localparam int AW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam int SW = $clog2(STEP_CYCLES);
   localparam logic [SW-1:0] PLAY_LAST = SW'(STEP_CYCLES - GAP_CYCLES - 2);
   localparam logic [SW-1:0] GAP_LAST  = SW'(GAP_CYCLES - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE, S_LOAD, S_PLAY, S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [18:0]   tcnt_q, tcnt_d;
   logic [18:0]   h_q, h_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic          tone_q, tone_d;
   logic          loop_q, loop_d;
   logic          spk_q, spk_d;
   logic          busy_q, busy_d;
   logic          tick_q, tick_d;
   logic          done_q, done_d;

   function automatic logic [18:0] half_period(input logic [3:0] c);
      logic [18:0] v;
      case (c)
         4'd1:    v = 19'd286351;
         4'd2:    v = 19'd255101;
         4'd3:    v = 19'd227272;
         4'd4:    v = 19'd202477;
         4'd5:    v = 19'd191109;
         4'd6:    v = 19'd170264;
         4'd7:    v = 19'd151684;
         4'd8:    v = 19'd127550;
         default: v = 19'd0;
      endcase
      v = v >> TONE_SHIFT;
      if (v == 19'd0) v = 19'd1;
      return v;
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      tcnt_d  = tcnt_q;
      scnt_d  = scnt_q;
      h_d     = h_q;
      tone_d  = tone_q;
      loop_d  = loop_q;
      spk_d   = spk_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      if (bus.stop) begin
         state_d = S_IDLE;
         spk_d   = 1'b0;
         tcnt_d  = '0;
         scnt_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  addr_d  = '0;
                  state_d = S_LOAD;
               end
            end
            S_LOAD: begin
               tcnt_d = '0;
               scnt_d = '0;
               spk_d  = 1'b0;
               h_d    = half_period(bus.song_note);
               tone_d = bus.song_note inside {[4'd1:4'd8]};
               if (bus.song_note != 4'd15) begin
                  state_d = S_PLAY;
               end else if (bus.loop_mode && addr_q != '0) begin
                  addr_d = '0;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_PLAY: begin
               if (tone_q) begin
                  if (tcnt_q == h_q - 19'd1) begin
                     tcnt_d = '0;
                     spk_d  = ~spk_q;
                  end else begin
                     tcnt_d = tcnt_q + 19'd1;
                  end
               end
               if (scnt_q == PLAY_LAST) begin
                  scnt_d  = '0;
                  spk_d   = 1'b0;
                  state_d = S_GAP;
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            S_GAP: begin
               spk_d = 1'b0;
               if (scnt_q == GAP_LAST) begin
                  scnt_d = '0;
                  if (addr_q != LAST_ADDR) begin
                     addr_d  = addr_q + 1'b1;
                     state_d = S_LOAD;
                  end else if (loop_q) begin
                     addr_d  = '0;
                     state_d = S_LOAD;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
         // Wrap decision is taken entering the last gap cycle so done can align with step_tick.
         if (state_d == S_GAP && scnt_d == GAP_LAST) begin
            tick_d = 1'b1;
            loop_d = bus.loop_mode;
            done_d = (addr_q == LAST_ADDR) && !bus.loop_mode;
         end
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         tcnt_q  <= '0;
         scnt_q  <= '0;
         h_q     <= '0;
         tone_q  <= 1'b0;
         loop_q  <= 1'b0;
         spk_q   <= 1'b0;
         busy_q  <= 1'b0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         tcnt_q  <= tcnt_d;
         scnt_q  <= scnt_d;
         h_q     <= h_d;
         tone_q  <= tone_d;
         loop_q  <= loop_d;
         spk_q   <= spk_d;
         busy_q  <= busy_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   assign bus.song_addr = addr_q;
   assign bus.speaker   = spk_q;
   assign bus.busy      = busy_q;
   assign bus.step_tick = tick_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_bgm_sequencer.sv
// Directed and randomized checks of bgm_sequencer against a
// cycle-offset arithmetic model of the song timeline.
module tb_bgm_sequencer;
   localparam int STEP = 40;
   localparam int GAP  = 8;
   localparam int NS   = 4;
   localparam int SH   = 14;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] rom [NS];
   bit         lp;
   int         checks = 0;
   int         errors = 0;

   bgm_sequencer_if #(.AW(2)) bus ();

   bgm_sequencer #(
      .STEP_CYCLES(STEP),
      .GAP_CYCLES (GAP),
      .NUM_STEPS  (NS),
      .TONE_SHIFT (SH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always_comb bus.song_note = rom[bus.song_addr];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int hp(input int c);
      int v;
      case (c)
         1: v = 286351;
         2: v = 255101;
         3: v = 227272;
         4: v = 202477;
         5: v = 191109;
         6: v = 170264;
         7: v = 151684;
         8: v = 127550;
         default: v = 0;
      endcase
      v = v >> SH;
      return (v == 0) ? 1 : v;
   endfunction

   // t = cycles since the LOAD of step 0 was entered
   task automatic expect_at(input int t);
      int k, ph, a, c, h;
      bit tn, tk;
      k  = t / STEP;
      ph = t % STEP;
      if (!lp && k >= NS) begin
         check($sformatf("busy@%0d", t), 32'(bus.busy), 0);
         check($sformatf("spk@%0d", t), 32'(bus.speaker), 0);
         check($sformatf("tick@%0d", t), 32'(bus.step_tick), 0);
         check($sformatf("done@%0d", t), 32'(bus.done), 0);
      end else begin
         a  = k % NS;
         c  = int'(rom[a]);
         tn = (c >= 1 && c <= 8);
         h  = hp(c);
         tk = (ph == STEP - 1);
         check($sformatf("addr@%0d", t), 32'(bus.song_addr), a);
         check($sformatf("busy@%0d", t), 32'(bus.busy), 1);
         check($sformatf("spk@%0d", t), 32'(bus.speaker),
               (tn && ph >= 1 && ph <= STEP - GAP - 1) ? ((ph - 1) / h) % 2 : 0);
         check($sformatf("tick@%0d", t), 32'(bus.step_tick), 32'(tk));
         check($sformatf("done@%0d", t), 32'(bus.done),
               32'(tk && !lp && a == NS - 1));
      end
   endtask

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      bus.start = 1'b1;
      tick1();
      bus.start = 1'b0;
   endtask

   task automatic run(input int from, input int n, input bit jit);
      for (int t = from; t < from + n; t++) begin
         expect_at(t);
         bus.start = (jit && t < 150) ? 1'($urandom_range(0, 1)) : 1'b0;
         tick1();
      end
      bus.start = 1'b0;
   endtask

   task automatic stop_check(input string tag);
      bus.stop = 1'b1;
      tick1();
      bus.stop = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_spk"}, 32'(bus.speaker), 0);
      check({tag, "_tick"}, 32'(bus.step_tick), 0);
      check({tag, "_done"}, 32'(bus.done), 0);
   endtask

   task automatic all_zero(input string tag);
      check({tag, "_addr"}, 32'(bus.song_addr), 0);
      check({tag, "_spk"}, 32'(bus.speaker), 0);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_tick"}, 32'(bus.step_tick), 0);
      check({tag, "_done"}, 32'(bus.done), 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.loop_mode = 1'b0;
      lp = 1'b0;
      for (int i = 0; i < NS; i++) rom[i] = 4'd0;
      #1;
      all_zero("rst");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick1();
         check("idle_busy", 32'(bus.busy), 0);
      end

      // one-shot song with a tone, a rest and done at the end
      rom[0] = 4'd8; rom[1] = 4'd0; rom[2] = 4'd3; rom[3] = 4'd5;
      go();
      run(0, 170, 1'b0);

      // looping song
      lp = 1'b1; bus.loop_mode = 1'b1;
      go();
      run(0, 240, 1'b0);
      stop_check("loopstop");

      // END code in step 1, one-shot
      rom[0] = 4'd3; rom[1] = 4'd15; rom[2] = 4'd0; rom[3] = 4'd0;
      lp = 1'b0; bus.loop_mode = 1'b0;
      go();
      run(0, 40, 1'b0);
      check("end1_addr", 32'(bus.song_addr), 1);
      check("end1_busy", 32'(bus.busy), 1);
      tick1();
      check("end1_done", 32'(bus.done), 1);
      check("end1_idle", 32'(bus.busy), 0);
      tick1();
      check("end1_done_off", 32'(bus.done), 0);

      // END code in step 1, looping: one extra LOAD then step 0 again
      lp = 1'b1; bus.loop_mode = 1'b1;
      go();
      run(0, 40, 1'b0);
      check("endl_addr1", 32'(bus.song_addr), 1);
      check("endl_done1", 32'(bus.done), 0);
      tick1();
      run(0, 40, 1'b0);
      stop_check("endlstop");

      // END at step 0 while looping must not lock up
      rom[0] = 4'd15; rom[1] = 4'd3;
      go();
      check("end0_busy", 32'(bus.busy), 1);
      tick1();
      check("end0_done", 32'(bus.done), 1);
      check("end0_idle", 32'(bus.busy), 0);
      tick1();
      check("end0_done_off", 32'(bus.done), 0);
      check("end0_idle2", 32'(bus.busy), 0);

      // stop mid-PLAY while the speaker is high
      rom[0] = 4'd8; rom[1] = 4'd0; rom[2] = 4'd3; rom[3] = 4'd5;
      lp = 1'b0; bus.loop_mode = 1'b0;
      go();
      run(0, 11, 1'b0);
      check("pre_stop_spk", 32'(bus.speaker), 1);
      stop_check("midstop");

      // start together with stop stays idle
      bus.start = 1'b1; bus.stop = 1'b1;
      tick1();
      bus.start = 1'b0; bus.stop = 1'b0;
      check("ss_busy", 32'(bus.busy), 0);
      tick1();
      check("ss_busy2", 32'(bus.busy), 0);

      // start pulses while busy are ignored
      go();
      run(0, 165, 1'b1);

      // asynchronous reset in the last GAP cycle of step 1
      go();
      run(0, 79, 1'b0);
      expect_at(79);
      #2 reset = 1'b1;
      #1;
      all_zero("areset");
      tick1();
      reset = 1'b0;
      tick1();
      check("post_rst_busy", 32'(bus.busy), 0);

      // randomized songs
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NS; i++) rom[i] = 4'($urandom_range(0, 14));
         lp = 1'($urandom_range(0, 1));
         bus.loop_mode = lp;
         go();
         if (lp) begin
            run(0, 200, 1'b1);
            stop_check("rndstop");
         end else begin
            run(0, 170, 1'b1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bgm_sequencer.md
BGM_SEQUENCER -- requirements
Module: bgm_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 10714284, meaning clk cycles per song step, including the silent gap.
REQ-002 SHALL have parameter GAP_CYCLES, default 1785714, meaning silent (staccato) cycles at the end of each step; 1 <= GAP_CYCLES < STEP_CYCLES-1.
REQ-003 SHALL have parameter NUM_STEPS, default 32, meaning song length limit; AW = clog2(NUM_STEPS).
REQ-004 SHALL have parameter TONE_SHIFT, default 0, meaning the right-shift applied to every half-period table value (used to speed up simulation).
REQ-005 SHALL have port clk, input, 1 bit: sole clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: begin playback from step 0.
REQ-008 SHALL have port stop, input, 1 bit: abort playback.
REQ-009 SHALL have port loop_mode, input, 1 bit: 1 = repeat song, 0 = one-shot.
REQ-010 SHALL have port song_addr, output, AW bits: current step index, driven to an external song ROM.
REQ-011 SHALL have port song_note, input, 4 bits: note code for song_addr, valid one cycle after song_addr changes.
REQ-012 SHALL have port speaker, output, 1 bit: square-wave audio.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port step_tick, output, 1 bit: one-cycle pulse at the end of each completed step.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when one-shot playback or an END code finishes.

Function
REQ-016 SHALL decode note codes to half-periods H as: 0 = rest; 1 F3 286351; 2 G3 255101; 3 A3 227272; 4 B3 202477; 5 C4 191109; 6 D4 170264; 7 E4 151684; 8 G4 127550; 9-14 = rest; 15 = END. Each value SHALL be shifted right by TONE_SHIFT; a shifted value of 0 SHALL be treated as 1.
REQ-017 SHALL implement the states IDLE, LOAD, PLAY and GAP.
REQ-018 In IDLE, when start=1 and stop=0, SHALL set song_addr=0 and enter LOAD on the next cycle.
REQ-019 LOAD SHALL last exactly 1 cycle, sample song_note, clear the tone and step counters, set speaker=0, and enter PLAY, unless the code is END.
REQ-020 On END in LOAD: if loop_mode=1 and song_addr!=0, SHALL set song_addr=0 and remain in LOAD; otherwise SHALL pulse done and enter IDLE.
REQ-021 PLAY SHALL last STEP_CYCLES-GAP_CYCLES-1 cycles. For tone codes, speaker SHALL toggle every H cycles, first toggling H cycles after PLAY entry; for rest codes, speaker SHALL stay 0.
REQ-022 GAP SHALL last GAP_CYCLES cycles with speaker forced to 0. On its last cycle, step_tick SHALL pulse.
REQ-023 On leaving GAP: if song_addr < NUM_STEPS-1, SHALL increment song_addr and enter LOAD.
REQ-024 On leaving GAP at song_addr = NUM_STEPS-1: if loop_mode=1, SHALL wrap song_addr to 0 and enter LOAD; otherwise SHALL pulse done in the same cycle as step_tick and enter IDLE.
REQ-025 Each non-END step SHALL occupy exactly STEP_CYCLES cycles from LOAD entry to the next LOAD or IDLE entry.
REQ-026 stop=1 in any state SHALL force IDLE and speaker=0 on the next edge, without a done or step_tick pulse. stop SHALL win over a simultaneous start.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 loop_mode SHALL be sampled only at wrap and END decision points, so a change mid-step has no effect until then.
REQ-029 The tone counter SHALL be at least 19 bits wide and the step counter at least clog2(STEP_CYCLES) bits, with no overflow for any legal parameter values.
REQ-030 All outputs SHALL be registered; speaker SHALL be glitch-free.

Reset
REQ-031 reset=1 SHALL immediately force state=IDLE, song_addr=0, speaker=0, busy=0, step_tick=0, done=0, and all counters to 0, regardless of the state at assertion.
REQ-032 After reset deasserts, the block SHALL remain in IDLE until a start pulse arrives.

Verification (STEP_CYCLES=40, GAP_CYCLES=8, NUM_STEPS=4, TONE_SHIFT=14)
REQ-033 Scenario: ROM={8,0,3,5}, loop_mode=0, pulse start. Required: step 0 speaker toggles every 7 cycles; step 1 stays silent; step_tick pulses at cycles 40/80/120/160 after LOAD entry; done pulses with the final step_tick; busy then falls.
REQ-034 Scenario: same ROM, loop_mode=1. Required: song_addr sequences 0,1,2,3,0,1 and done never pulses.
REQ-035 Scenario: ROM={3,15,x,x} with loop_mode=0 and again with loop_mode=1. Required: loop_mode=0 gives done in the LOAD of step 1; loop_mode=1 gives a return to step 0 after exactly one extra LOAD cycle.
REQ-036 Scenario: ROM={15,...}, loop_mode=1. Required: done pulses and the block returns to IDLE (no lock-up).
REQ-037 Scenario: stop mid-PLAY, start+stop asserted together in IDLE, and start while busy. Required: stop gives IDLE and speaker=0 one cycle later; start+stop stays IDLE; start while busy leaves song_addr unchanged.
REQ-038 Scenario: reset asserted asynchronously mid-GAP. Required: all outputs 0 before the next clk edge.
